// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
// The CHK state is only reachable when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;

  localparam int BYTES_PER_WORD    = 4;
  localparam int DEFAULT_ADDR_W    = 10;
  localparam int DEFAULT_MAX_WORDS = 1024;

  typedef enum logic [2:0] {
    HDR   = 3'd0,
    LOAD  = 3'd1,
    FLUSH = 3'd2,
    CHK   = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted stream bytes into little-endian 32-bit words.
// word/word_valid are combinational so the consumer can register the word on the accepting edge.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        accept,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  byte_cnt;
  logic [23:0] lower;

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt <= 2'd0;
      lower    <= 24'd0;
    end else if (accept) begin
      byte_cnt <= byte_cnt + 2'd1;
      case (byte_cnt)
        2'd0:    lower[7:0]   <= in_data;
        2'd1:    lower[15:8]  <= in_data;
        2'd2:    lower[23:16] <= in_data;
        default: ;
      endcase
    end
  end

  // The fourth byte goes straight to [31:24] without being stored.
  assign word       = {in_data, lower};
  assign word_valid = accept && (byte_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length header, then N words written to imem from address 0, then core release.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum word before release.
//
// state | meaning
// HDR   | collecting the 4-byte length word
// LOAD  | collecting image words, one imem write per word
// FLUSH | one cycle before release (final strobe, or no-write cases)
// CHK   | collecting the checksum word (checksum build only)
// DONE  | image loaded, core released
// ERROR | load aborted, core held in reset
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int MAX_WORDS = DEFAULT_MAX_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = ADDR_W + 1;

  state_t           state;
  logic             accept;
  logic [31:0]      word;
  logic             word_valid;
  logic [CNT_W-1:0] word_cnt;
  logic [CNT_W-1:0] last_idx;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]      csum;
`endif

  always_comb begin
    in_ready = 1'b0;
    case (state)
      HDR, LOAD: in_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK:       in_ready = 1'b1;
`endif
      default:   in_ready = 1'b0;
    endcase
  end

  assign accept = in_valid && in_ready;

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .accept     (accept),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HDR;
      word_cnt   <= '0;
      last_idx   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      core_rst   <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum       <= 32'd0;
`endif
    end else begin
      imem_we <= 1'b0;
      case (state)
        HDR: begin
          if (word_valid) begin
            if (word == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state <= CHK;
`else
              state <= FLUSH;
`endif
            end else if (word > 32'(MAX_WORDS)) begin
              state <= ERROR;
              err   <= 1'b1;
            end else begin
              state    <= LOAD;
              last_idx <= CNT_W'(word - 32'd1);
            end
          end
        end
        LOAD: begin
          if (word_valid) begin
            imem_we    <= 1'b1;
            imem_addr  <= word_cnt[ADDR_W-1:0];
            imem_wdata <= word;
            word_cnt   <= word_cnt + CNT_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum       <= csum ^ word;
            if (word_cnt == last_idx) state <= CHK;
`else
            if (word_cnt == last_idx) state <= FLUSH;
`endif
          end
        end
        FLUSH: begin
          state    <= DONE;
          done     <= 1'b1;
          core_rst <= 1'b0;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        // Match routes through FLUSH so release lands one edge after the last byte.
        CHK: begin
          if (word_valid) begin
            if (word == csum) begin
              state <= FLUSH;
            end else begin
              state <= ERROR;
              err   <= 1'b1;
            end
          end
        end
`endif
        DONE, ERROR: ;
        default: state <= HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table vectors, timing sequences and randomized images.
// Checksum-specific sequences are compiled in when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

  localparam int ADDR_W    = 10;
  localparam int MAX_WORDS = 1024;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        in_data = 8'd0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_rst;
  logic              done;
  logic              err;

  imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst   (core_rst),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;
  wr_t wr_q[$];

  // Every strobe lasts exactly one cycle, so one sample per low phase sees it once.
  always @(negedge clk) begin
    if (imem_we) wr_q.push_back('{addr: imem_addr, data: imem_wdata});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_imem_we", imem_we, 0);
    check("rst_imem_addr", imem_addr, 0);
    check("rst_imem_wdata", imem_wdata, 0);
    check("rst_core_rst", core_rst, 1);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    wr_q.delete();
  endtask

  // Returns #1 after the edge that accepted the byte.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: in_ready 0 for 50 cycles, required 1");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
  endtask

  // Streams header, image and (checksum build) checksum, then checks outcome and writes.
  task automatic run_image(input string tag, input logic [31:0] n, input int gap_max,
                           input logic [31:0] flip, input logic exp_done,
                           input logic exp_err, input int exp_nw);
    logic [31:0] words[$];
    logic [31:0] x;
    int          nw;
    do_reset();
    send_word(n, $urandom_range(0, gap_max));
    if (n <= MAX_WORDS) begin
      nw = int'(n);
      x = 32'd0;
      for (int i = 0; i < nw; i++) begin
        words.push_back($urandom);
        x = x ^ words[i];
        send_word(words[i], $urandom_range(0, gap_max));
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_word(x ^ flip, $urandom_range(0, gap_max));
`else
      if (flip != 32'd0) $display("note: %s checksum corruption ignored, no checksum word", tag);
`endif
    end
    repeat (3) @(negedge clk);
    check({tag, "_done"}, done, exp_done);
    check({tag, "_err"}, err, exp_err);
    check({tag, "_core_rst"}, core_rst, !exp_done);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_nwrites"}, wr_q.size(), exp_nw);
    for (int i = 0; i < wr_q.size() && i < words.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), wr_q[i].addr, i);
      check($sformatf("%s_data%0d", tag, i), wr_q[i].data, words[i]);
    end
  endtask

  task automatic nominal(input string tag, input int gap);
    do_reset();
    send_word(32'd2, gap);
    send_word(32'h2000_0013, gap);
    check({tag, "_w0_we"}, imem_we, 1);
    check({tag, "_w0_addr"}, imem_addr, 0);
    check({tag, "_w0_data"}, imem_wdata, 32'h2000_0013);
    send_word(32'h0000_0008, gap);
    check({tag, "_w1_we"}, imem_we, 1);
    check({tag, "_w1_addr"}, imem_addr, 1);
    check({tag, "_w1_data"}, imem_wdata, 32'h0000_0008);
    check({tag, "_w1_done_low"}, done, 0);
    check({tag, "_w1_core_rst"}, core_rst, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_word(32'h2000_0013 ^ 32'h0000_0008, gap);
    check({tag, "_csum_done_low"}, done, 0);
`endif
    @(posedge clk);
    #1;
    check({tag, "_rel_done"}, done, 1);
    check({tag, "_rel_core_rst"}, core_rst, 0);
    check({tag, "_rel_we"}, imem_we, 0);
    check({tag, "_rel_in_ready"}, in_ready, 0);
    repeat (4) @(negedge clk);
    check({tag, "_nwrites"}, wr_q.size(), 2);
    if (wr_q.size() == 2) begin
      check({tag, "_q0_addr"}, wr_q[0].addr, 0);
      check({tag, "_q0_data"}, wr_q[0].data, 32'h2000_0013);
      check({tag, "_q1_addr"}, wr_q[1].addr, 1);
      check({tag, "_q1_data"}, wr_q[1].data, 32'h0000_0008);
    end
  endtask

  typedef struct {
    string       tag;
    logic [31:0] n;
    int          gap_max;
    logic        exp_done;
    logic        exp_err;
    int          exp_nw;
  } vec_t;

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t        vecs[7];
    logic [31:0] n, flip;
    logic        m_err;
    int          r;

    vecs[0] = '{"len1",     32'd1,          0, 1'b1, 1'b0, 1};
    vecs[1] = '{"len5gap",  32'd5,          3, 1'b1, 1'b0, 5};
    vecs[2] = '{"len0",     32'd0,          1, 1'b1, 1'b0, 0};
    vecs[3] = '{"len1024",  32'd1024,       0, 1'b1, 1'b0, 1024};
    vecs[4] = '{"len1025",  32'd1025,       0, 1'b0, 1'b1, 0};
    vecs[5] = '{"len64k",   32'h0001_0000,  0, 1'b0, 1'b1, 0};
    vecs[6] = '{"lenmax",   32'hFFFF_FFFF,  0, 1'b0, 1'b1, 0};

    nominal("nom", 0);
    nominal("gap3", 3);

    // Zero length: no write, release one edge after the last header byte.
    do_reset();
    send_word(32'd0, 0);
    check("zero_we", imem_we, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("zero_chk_ready", in_ready, 1);
    send_word(32'd0, 0);
`endif
    check("zero_done_early", done, 0);
    @(posedge clk);
    #1;
    check("zero_done", done, 1);
    check("zero_core_rst", core_rst, 0);
    check("zero_in_ready", in_ready, 0);
    check("zero_nwrites", wr_q.size(), 0);

    // Oversize header: error on the accepting edge.
    do_reset();
    send_word(32'd1025, 0);
    check("over_err", err, 1);
    check("over_core_rst", core_rst, 1);
    check("over_in_ready", in_ready, 0);
    repeat (5) @(negedge clk);
    check("over_err_hold", err, 1);
    check("over_done", done, 0);
    check("over_ready_hold", in_ready, 0);
    check("over_nwrites", wr_q.size(), 0);

    // Reset after 6 bytes of a 3-word image, then a clean restream.
    do_reset();
    send_word(32'd3, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    do_reset();
    check("midrst_nwrites_after_rst", wr_q.size(), 0);
    run_image("midrst", 32'd3, 0, 32'd0, 1'b1, 1'b0, 3);

`ifdef IMEM_LOADER_CHECKSUM_EN
    do_reset();
    send_word(32'd2, 0);
    send_word(32'h1111_1111, 0);
    send_word(32'h2222_2222, 0);
    send_word(32'h3333_3333, 0);
    check("csum_ok_err", err, 0);
    @(posedge clk);
    #1;
    check("csum_ok_done", done, 1);
    check("csum_ok_core_rst", core_rst, 0);
    do_reset();
    send_word(32'd2, 0);
    send_word(32'h1111_1111, 0);
    send_word(32'h2222_2222, 0);
    send_word(32'h3333_3334, 0);
    check("csum_bad_err", err, 1);
    check("csum_bad_done", done, 0);
    check("csum_bad_core_rst", core_rst, 1);
    check("csum_bad_nwrites", wr_q.size(), 2);
`endif

    for (int i = 0; i < 7; i++)
      run_image(vecs[i].tag, vecs[i].n, vecs[i].gap_max, 32'd0,
                vecs[i].exp_done, vecs[i].exp_err, vecs[i].exp_nw);

    for (int it = 0; it < 20; it++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      n = 32'd0;
      else if (r == 1) n = 32'd1025 + 32'($urandom_range(0, 1 << 20));
      else             n = 32'($urandom_range(1, 12));
      flip = 32'd0;
      m_err = (n > MAX_WORDS);
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (!m_err && $urandom_range(0, 3) == 0) begin
        flip  = 32'd1 << $urandom_range(0, 31);
        m_err = 1'b1;
      end
`endif
      run_image($sformatf("rnd%0d", it), n, $urandom_range(0, 2), flip,
                !m_err, m_err, (n > MAX_WORDS) ? 0 : int'(n));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
